// File: rtl/mips_avalon_pkg.sv
// -----------------------------------------------------------------------------
// mips_avalon_pkg
// Shared types and helpers for the Avalon-MM RAM responder.
//   state_t           : responder FSM states (idle, wait-count, acknowledge)
//   DEFAULT_BASE_ADDR : reset-vector region where word 0 of the RAM lives
//   be_to_mask()      : expands a 4-bit byteenable into a 32-bit bit mask
// -----------------------------------------------------------------------------
package mips_avalon_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

    function automatic logic [31:0] be_to_mask(input logic [3:0] i_be);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{i_be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/mips_avalon_ram_responder_if.sv
// -----------------------------------------------------------------------------
// mips_avalon_ram_responder_if
// Avalon-MM bus between the cache controller (master) and the RAM responder.
//   address/write/read/writedata/byteenable : master -> responder
//   waitrequest/readdata/err                : responder -> master
// -----------------------------------------------------------------------------
interface mips_avalon_ram_responder_if;

    logic [31:0] address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        err;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata, err
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata, err
    );

endinterface

// File: rtl/mips_byte_ram.sv
// -----------------------------------------------------------------------------
// mips_byte_ram
// Single-port MEM_WORDS x 32 RAM with byte-masked synchronous write and
// synchronous, enable-gated read. The read register only changes when i_re
// is high, so o_rdata holds its value between reads.
//   i_clk   : clock
//   i_we    : write enable (lanes selected by i_be)
//   i_re    : read enable
//   i_addr  : word index
//   i_wdata : write data
//   i_be    : byte lane enables
//   o_rdata : registered read data
// -----------------------------------------------------------------------------
module mips_byte_ram
    import mips_avalon_pkg::*;
#(
    parameter int unsigned MEM_WORDS     = 1024,
    parameter string       RAM_INIT_FILE = "",
    localparam int unsigned AW           = $clog2(MEM_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_be,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;
    logic [31:0] w_mask;

    assign w_mask = be_to_mask(i_be);

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= (r_mem[i_addr] & ~w_mask) | (i_wdata & w_mask);
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_avalon_ram_responder.sv
// -----------------------------------------------------------------------------
// mips_avalon_ram_responder
// Avalon-MM slave terminating the memory port of the MIPS cache controller.
// Word-addressed RAM mapped at BASE_ADDR, byte-enable writes, fixed read and
// write waitrequest latency, sticky error flag for bad transactions.
//   i_clk  : rising-edge clock
//   i_rst  : synchronous reset, active low
//   io_bus : Avalon-MM slave modport (address/read/write/writedata/byteenable
//            in; waitrequest/readdata/err out)
// BASE_ADDR is expected to be word aligned.
// -----------------------------------------------------------------------------
module mips_avalon_ram_responder
    import mips_avalon_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter int unsigned MEM_WORDS     = 1024,
    parameter int unsigned READ_DELAY    = 2,
    parameter int unsigned WRITE_DELAY   = 2,
    parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    mips_avalon_ram_responder_if.slave        io_bus
);

    localparam int unsigned AW     = $clog2(MEM_WORDS);
    localparam logic [3:0]  RD_DLY = READ_DELAY[3:0];
    localparam logic [3:0]  WR_DLY = WRITE_DELAY[3:0];

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [31:0]     r_addr;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic            r_rd_in;
    logic            r_wr_in;
    logic            r_is_write;
    logic            r_bad;
    logic            r_proto;
    logic            r_err;
    logic            r_rd_zero;

    logic            w_req;
    logic [29:0]     w_woff;
    logic [AW-1:0]   w_live_idx;
    logic            w_live_bad;
    logic [3:0]      w_dly;
    logic            w_unstable;
    logic            w_ram_we;
    logic            w_ram_re;
    logic [AW-1:0]   w_ram_addr;
    logic [31:0]     w_ram_rdata;

    assign w_req = io_bus.read | io_bus.write;

    // Word offset from base; with an aligned base this equals (address-BASE)>>2.
    assign w_woff     = io_bus.address[31:2] - BASE_ADDR[31:2];
    assign w_live_idx = w_woff[AW-1:0];
    assign w_live_bad = (w_woff[29:AW] != '0) | (io_bus.address[1:0] != 2'b00) |
                        (io_bus.read & io_bus.write);

    // Read wins when both strobes are high; that case is flagged as bad anyway.
    assign w_dly = io_bus.read ? RD_DLY : WR_DLY;

    // Any departure from the latched request while the master is being stalled.
    assign w_unstable = ~w_req |
                        (io_bus.address != r_addr) |
                        (io_bus.read != r_rd_in) |
                        (io_bus.write != r_wr_in) |
                        (io_bus.write & ((io_bus.writedata != r_wdata) |
                                         (io_bus.byteenable != r_be)));

    // RAM reads on the ACK-entry edge (from IDLE when the delay is zero,
    // otherwise from the last WAIT cycle); writes on the ACK-exit edge.
    // The two edges never coincide, so one port suffices.
    assign w_ram_addr = (r_state == StIdle) ? w_live_idx : r_idx;
    assign w_ram_re   = i_rst & (
        ((r_state == StIdle) & io_bus.read & (RD_DLY == 4'd0) & ~w_live_bad) |
        ((r_state == StWait) & (r_cnt == 4'd1) & ~r_is_write & ~r_bad));
    assign w_ram_we   = i_rst & (r_state == StAck) & r_is_write & ~r_bad;

    mips_byte_ram #(
        .MEM_WORDS     (MEM_WORDS),
        .RAM_INIT_FILE (RAM_INIT_FILE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_rd_zero <= 1'b1;
            r_bad     <= 1'b0;
            r_proto   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_addr     <= io_bus.address;
                        r_idx      <= w_live_idx;
                        r_wdata    <= io_bus.writedata;
                        r_be       <= io_bus.byteenable;
                        r_rd_in    <= io_bus.read;
                        r_wr_in    <= io_bus.write;
                        r_is_write <= io_bus.write & ~io_bus.read;
                        r_bad      <= w_live_bad;
                        r_proto    <= 1'b0;
                        r_cnt      <= w_dly;
                        if (w_dly == 4'd0) begin
                            r_state <= StAck;
                            if (io_bus.read) begin
                                r_rd_zero <= w_live_bad;
                            end
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_unstable) begin
                        r_proto <= 1'b1;
                    end
                    if (r_cnt == 4'd1) begin
                        r_state <= StAck;
                        if (!r_is_write) begin
                            r_rd_zero <= r_bad;
                        end
                    end
                end
                StAck: begin
                    r_state <= StIdle;
                    if (r_bad | r_proto) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.waitrequest = (r_state != StAck) & w_req;
    // Zero is forced after reset and for rejected reads; otherwise the RAM
    // read register, which only moves on an accepted read.
    assign io_bus.readdata    = r_rd_zero ? 32'h0 : w_ram_rdata;
    assign io_bus.err         = r_err;

endmodule

// File: tb/tb_mips_avalon_ram_responder.sv
`timescale 1ns/1ps
module tb_mips_avalon_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel0;
    logic        t_read;
    logic        t_write;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic        w_wait;
    logic [31:0] w_rdata;
    logic        w_err;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    time         t_ack;
    time         t_prev;

    always #5 clk = ~clk;

    mips_avalon_ram_responder_if bus2 ();
    mips_avalon_ram_responder_if bus0 ();

    // Stimulus is routed to one instance at a time.
    assign bus2.address    = t_addr;
    assign bus2.writedata  = t_wdata;
    assign bus2.byteenable = t_be;
    assign bus2.read       = t_read & ~sel0;
    assign bus2.write      = t_write & ~sel0;
    assign bus0.address    = t_addr;
    assign bus0.writedata  = t_wdata;
    assign bus0.byteenable = t_be;
    assign bus0.read       = t_read & sel0;
    assign bus0.write      = t_write & sel0;

    assign w_wait  = sel0 ? bus0.waitrequest : bus2.waitrequest;
    assign w_rdata = sel0 ? bus0.readdata : bus2.readdata;
    assign w_err   = sel0 ? bus0.err : bus2.err;

    mips_avalon_ram_responder #(
        .RAM_INIT_FILE (""),
        .MEM_WORDS     (1024),
        .READ_DELAY    (2),
        .WRITE_DELAY   (2),
        .BASE_ADDR     (32'hBFC00000)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .io_bus (bus2)
    );

    mips_avalon_ram_responder #(
        .RAM_INIT_FILE (""),
        .MEM_WORDS     (1024),
        .READ_DELAY    (0),
        .WRITE_DELAY   (0),
        .BASE_ADDR     (32'hBFC00000)
    ) dut0 (
        .i_clk  (clk),
        .i_rst  (rst_n),
        .io_bus (bus0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        @(posedge clk);
        #1;
        t_read  = rd;
        t_write = wr;
        t_addr  = addr;
        t_wdata = wdata;
        t_be    = be;
    endtask

    // Counts stall cycles from cycle 'start' until waitrequest drops (bounded).
    task automatic wait_ack(input string tag, input int start, input int lat, input logic rd);
        int n;
        logic [31:0] exp;
        n = start;
        @(negedge clk);
        while (w_wait === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        if (rd) begin
            exp = exp_q.pop_front();
            check({tag, " readdata"}, w_rdata, exp);
        end
        t_ack = $time;
    endtask

    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int lat, input logic [31:0] exp_rd);
        drive(rd, wr, addr, wdata, be);
        if (rd) exp_q.push_back(exp_rd);
        wait_ack(tag, 0, lat, rd);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        t_read  = 1'b0;
        t_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        t_read  = 1'b0;
        t_write = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b1;
        sel0    = 1'b0;
        t_read  = 1'b0;
        t_write = 1'b0;
        t_addr  = 32'h0;
        t_wdata = 32'h0;
        t_be    = 4'hF;

        // Reset state.
        do_reset();
        check("reset err", 32'(w_err), 32'd0);
        check("reset readdata", w_rdata, 32'h0);
        check("reset waitrequest", 32'(w_wait), 32'd0);

        // Read latency (word 0 seeded through the bus).
        txn("seed w0", 0, 1, 32'hBFC00000, 32'h3C011234, 4'hF, 3, 32'h0);
        txn("read w0", 1, 0, 32'hBFC00000, 32'h0, 4'hF, 3, 32'h3C011234);
        idle();
        check("read w0 err", 32'(w_err), 32'd0);

        // Byte-enable write and zero-lane write.
        txn("seed w4", 0, 1, 32'hBFC00010, 32'h11223344, 4'hF, 3, 32'h0);
        txn("be write", 0, 1, 32'hBFC00010, 32'hAABBCCDD, 4'b0101, 3, 32'h0);
        txn("be readback", 1, 0, 32'hBFC00010, 32'h0, 4'hF, 3, 32'h11BB33DD);
        txn("be0 write", 0, 1, 32'hBFC00010, 32'hFFFFFFFF, 4'b0000, 3, 32'h0);
        txn("be0 readback", 1, 0, 32'hBFC00010, 32'h0, 4'b0000, 3, 32'h11BB33DD);
        idle();
        check("be0 err", 32'(w_err), 32'd0);

        // Out-of-range read.
        txn("read w0 again", 1, 0, 32'hBFC00000, 32'h0, 4'hF, 3, 32'h3C011234);
        txn("oor read", 1, 0, 32'hBFC01000, 32'h0, 4'hF, 3, 32'h0);
        idle();
        check("oor err", 32'(w_err), 32'd1);

        // Out-of-range write must not alias onto word 0.
        do_reset();
        check("reset2 err", 32'(w_err), 32'd0);
        txn("oor write", 0, 1, 32'hBFC01000, 32'hDEADBEEF, 4'hF, 3, 32'h0);
        idle();
        check("oor write err", 32'(w_err), 32'd1);
        do_reset();
        txn("w0 intact", 1, 0, 32'hBFC00000, 32'h0, 4'hF, 3, 32'h3C011234);

        // Misaligned read.
        txn("misaligned", 1, 0, 32'hBFC00002, 32'h0, 4'hF, 3, 32'h0);
        idle();
        check("misaligned err", 32'(w_err), 32'd1);

        // Read and write together.
        do_reset();
        txn("rw both", 1, 1, 32'hBFC00010, 32'hFFFFFFFF, 4'hF, 3, 32'h0);
        idle();
        check("rw both err", 32'(w_err), 32'd1);
        do_reset();
        txn("rw unchanged", 1, 0, 32'hBFC00010, 32'h0, 4'hF, 3, 32'h11BB33DD);

        // Reset in the middle of a write.
        txn("seed w8", 0, 1, 32'hBFC00020, 32'h12345678, 4'hF, 3, 32'h0);
        txn("read w8", 1, 0, 32'hBFC00020, 32'h0, 4'hF, 3, 32'h12345678);
        drive(0, 1, 32'hBFC00020, 32'h55555555, 4'hF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid wait follows req", 32'(w_wait), 32'd1);
        t_write = 1'b0;
        #1;
        check("rstmid wait idle", 32'(w_wait), 32'd0);
        check("rstmid err", 32'(w_err), 32'd0);
        check("rstmid readdata", w_rdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        txn("rstmid word", 1, 0, 32'hBFC00020, 32'h0, 4'hF, 3, 32'h12345678);

        // Address changed while stalled: latched address wins, err raised.
        txn("seed w2", 0, 1, 32'hBFC00008, 32'h87654321, 4'hF, 3, 32'h0);
        txn("seed w3", 0, 1, 32'hBFC0000C, 32'h0C0C0C0C, 4'hF, 3, 32'h0);
        idle();
        check("pre unstable err", 32'(w_err), 32'd0);
        drive(1, 0, 32'hBFC00008, 32'h0, 4'hF);
        exp_q.push_back(32'h87654321);
        @(posedge clk);
        #1;
        t_addr = 32'hBFC0000C;
        wait_ack("unstable", 1, 3, 1'b1);
        idle();
        check("unstable err", 32'(w_err), 32'd1);

        // Write dropped mid-wait still commits and flags err.
        do_reset();
        drive(0, 1, 32'hBFC00030, 32'hA5A5A5A5, 4'hF);
        @(posedge clk);
        #1;
        t_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("drop err", 32'(w_err), 32'd1);
        txn("drop commit", 1, 0, 32'hBFC00030, 32'h0, 4'hF, 3, 32'hA5A5A5A5);
        idle();

        // Zero-delay instance: back-to-back write then read.
        sel0 = 1'b1;
        do_reset();
        check("zd reset readdata", w_rdata, 32'h0);
        txn("zd write", 0, 1, 32'hBFC00004, 32'h13579BDF, 4'hF, 1, 32'h0);
        t_prev = t_ack;
        txn("zd read", 1, 0, 32'hBFC00004, 32'h0, 4'hF, 1, 32'h13579BDF);
        check("zd spacing", 32'(t_ack - t_prev), 32'd20);
        idle();
        check("zd err", 32'(w_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
